// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU types, constants and the BGP palette lookup
package ppu_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} BgFifoState;
    localparam int X_MAX = 160;
    localparam int DEPTH = 8;
    typedef logic [1:0] PixelIdx;
    function automatic logic [1:0] bgp_map(PixelIdx idx, logic [7:0] bgp);
        return bgp[{idx, 1'b1} -: 2];
    endfunction
endpackage

// File: rtl/bg_pixel_fifo_if.sv
// bg_pixel_fifo_if: fetcher/LCD-side signals of the background pixel FIFO
interface bg_pixel_fifo_if #(parameter int X_MAX = ppu_pkg::X_MAX);
    import ppu_pkg::*;
    localparam int XW = $clog2(X_MAX);
    logic              tclk_in;
    logic              line_start_in;
    logic              window_trigger_in;
    logic              pause_in;
    logic [7:0]        SCX_in;
    logic [7:0]        BGP_in;
    logic              bg_enable_in;
    logic              valid_pixels_in;
    PixelIdx [7:0]     pixels_in;
    logic              fifo_empty_out;
    logic              pixel_valid_out;
    PixelIdx           pixel_index_out;
    logic [1:0]        color_out;
    logic [XW-1:0]     x_out;
    logic              line_done_out;
    logic              overflow_out;
    modport master (
        output tclk_in, line_start_in, window_trigger_in, pause_in, SCX_in, BGP_in,
               bg_enable_in, valid_pixels_in, pixels_in,
        input  fifo_empty_out, pixel_valid_out, pixel_index_out, color_out, x_out,
               line_done_out, overflow_out
    );
    modport slave (
        input  tclk_in, line_start_in, window_trigger_in, pause_in, SCX_in, BGP_in,
               bg_enable_in, valid_pixels_in, pixels_in,
        output fifo_empty_out, pixel_valid_out, pixel_index_out, color_out, x_out,
               line_done_out, overflow_out
    );
endinterface

// File: rtl/bg_pixel_fifo.sv
// bg_pixel_fifo: 8-entry background pixel shifter with SCX discard, BGP mapping and X tracking
module bg_pixel_fifo
    import ppu_pkg::*;
#(
    parameter int X_MAX = ppu_pkg::X_MAX
) (
    input logic            clk_in,
    input logic            rst_n_in,
    bg_pixel_fifo_if.slave bus
);
    localparam int XW = $clog2(X_MAX);
    localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);

    BgFifoState        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [XW-1:0]     x_q, x_d;
    logic [2:0]        discard_q, discard_d;
    PixelIdx [7:0]     fifo_q, fifo_d;
    PixelIdx           idx_q, idx_d;
    logic [1:0]        color_q, color_d;
    logic              prev_valid_q, pv_q, pv_d, ld_q, ld_d, ovf_q, ovf_d;
    logic              push_edge, pop, last;
    PixelIdx           emit_idx;
    logic              unused_scx;

    assign unused_scx = &{1'b0, bus.SCX_in[7:3]};
    assign push_edge  = bus.valid_pixels_in & ~prev_valid_q;
    assign pop        = bus.tclk_in & (count_q != 4'd0) & ~bus.pause_in;
    assign emit_idx   = bus.bg_enable_in ? fifo_q[0] : 2'd0;
    assign last       = x_q == X_LAST;

    assign bus.fifo_empty_out  = count_q == 4'd0;
    assign bus.pixel_valid_out = pv_q;
    assign bus.pixel_index_out = idx_q;
    assign bus.color_out       = color_q;
    assign bus.x_out           = x_q;
    assign bus.line_done_out   = ld_q;
    assign bus.overflow_out    = ovf_q;

    // Register all state; reset takes effect immediately, even mid-line.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            count_q      <= '0;
            x_q          <= '0;
            discard_q    <= '0;
            fifo_q       <= '0;
            idx_q        <= '0;
            color_q      <= '0;
            prev_valid_q <= 1'b0;
            pv_q         <= 1'b0;
            ld_q         <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            x_q          <= x_d;
            discard_q    <= discard_d;
            fifo_q       <= fifo_d;
            idx_q        <= idx_d;
            color_q      <= color_d;
            prev_valid_q <= bus.valid_pixels_in;
            pv_q         <= pv_d;
            ld_q         <= ld_d;
            ovf_q        <= ovf_d;
        end
    end

    // Line start beats everything; in SHIFT a window flush cancels pop and load, else load or pop.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        x_d       = x_q;
        discard_d = discard_q;
        fifo_d    = fifo_q;
        idx_d     = idx_q;
        color_d   = color_q;
        ovf_d     = ovf_q;
        pv_d      = 1'b0;
        ld_d      = 1'b0;
        if (bus.line_start_in) begin
            state_d   = SHIFT;
            count_d   = '0;
            x_d       = '0;
            discard_d = bus.SCX_in[2:0];
        end else if (state_q == SHIFT) begin
            if (push_edge && count_q != 4'd0) ovf_d = 1'b1;
            if (bus.window_trigger_in) begin
                count_d   = '0;
                discard_d = '0;
            end else if (push_edge && count_q == 4'd0) begin
                fifo_d  = bus.pixels_in;
                count_d = 4'(DEPTH);
            end else if (pop) begin
                fifo_d  = fifo_q >> 2;
                count_d = count_q - 4'd1;
                if (discard_q != 3'd0) begin
                    discard_d = discard_q - 3'd1;
                end else begin
                    pv_d    = 1'b1;
                    idx_d   = emit_idx;
                    color_d = bgp_map(emit_idx, bus.BGP_in);
                    x_d     = last ? '0 : x_q + XW'(1);
                    state_d = last ? DONE : SHIFT;
                    ld_d    = last;
                end
            end
        end
    end
endmodule
